mux153_rr_arbiter: RTL and testbench



---
 rtl/ttl_mux_ctrl_pkg.sv | 16 +
 rtl/mux153_rr_arbiter_rr_pick.sv | 31 +++
 rtl/mux153_rr_arbiter.sv | 112 +++++++++++
 tb/tb_mux153_rr_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ttl_mux_ctrl_pkg.sv
// Shared definitions for TTL-style mux controllers: FSM state encoding and
// a width helper that never returns a zero-width counter.
package ttl_mux_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  // Bits needed to hold values 0..n-1, with a minimum of one bit.
  function automatic int rr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux153_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: finds the first asserted request searching
// upward from last+1 with wrap-around.
module rr_pick
  import ttl_mux_ctrl_pkg::*;
#(
  parameter  int WIDTH     = 4,
  localparam int SEL_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     req,
  input  logic [SEL_WIDTH-1:0] last,
  output logic                 any,
  output logic [SEL_WIDTH-1:0] idx
);

  logic [SEL_WIDTH-1:0] cand;

  // WIDTH is a power of two, so the select-width add wraps naturally.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 1; i <= WIDTH; i++) begin
      cand = last + SEL_WIDTH'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux153_rr_arbiter.sv
// Round-robin sequencer for a shared 74x153-style dual 4:1 mux: the select
// only moves while both halves are disabled, so outputs never glitch.
module mux153_rr_arbiter
  import ttl_mux_ctrl_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int SETUP_CYC = 1,
  parameter  int HOLD_MAX  = 16,
  localparam int SEL_WIDTH = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     req,
  input  logic [1:0]           half_en,
  output logic [WIDTH-1:0]     gnt,
  output logic [SEL_WIDTH-1:0] A_B,
  output logic                 G1_n,
  output logic                 G2_n,
  output logic                 busy
);

  localparam int SCW = rr_width(SETUP_CYC + 1);
  localparam int HCW = rr_width(HOLD_MAX + 1);

  state_e               state_q;
  logic [WIDTH-1:0]     gnt_q;
  logic [SEL_WIDTH-1:0] ab_q;
  logic [SEL_WIDTH-1:0] last_q;
  logic                 g1n_q;
  logic                 g2n_q;
  logic [SCW-1:0]       setup_cnt_q;
  logic [HCW-1:0]       hold_cnt_q;

  logic                 pick_any;
  logic [SEL_WIDTH-1:0] pick_idx;
  logic                 req_k;
  logic                 setup_done;
  logic                 hold_done;

  rr_pick #(.WIDTH(WIDTH)) u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // The current owner is always the input selected by A_B.
  assign req_k      = req[ab_q];
  assign setup_done = (int'(setup_cnt_q) >= SETUP_CYC - 1);
  assign hold_done  = (HOLD_MAX != 0) && (int'(hold_cnt_q) >= HOLD_MAX - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      ab_q        <= '0;
      last_q      <= SEL_WIDTH'(WIDTH - 1);
      g1n_q       <= 1'b1;
      g2n_q       <= 1'b1;
      setup_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          gnt_q <= '0;
          g1n_q <= 1'b1;
          g2n_q <= 1'b1;
          if (pick_any) begin
            ab_q        <= pick_idx;
            last_q      <= pick_idx;
            setup_cnt_q <= '0;
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (!req_k) begin
            state_q <= ST_IDLE;
          end else if (setup_done) begin
            state_q    <= ST_GRANT;
            gnt_q      <= WIDTH'(1) << ab_q;
            g1n_q      <= ~half_en[0];
            g2n_q      <= ~half_en[1];
            hold_cnt_q <= '0;
          end else begin
            setup_cnt_q <= setup_cnt_q + SCW'(1);
          end
        end
        ST_GRANT: begin
          // Release always goes through IDLE before A_B may move.
          if (!req_k || hold_done) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            g1n_q   <= 1'b1;
            g2n_q   <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + HCW'(1);
            g1n_q      <= ~half_en[0];
            g2n_q      <= ~half_en[1];
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign A_B  = ab_q;
  assign G1_n = g1n_q;
  assign G2_n = g2n_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux153_rr_arbiter.sv
// Bench for mux153_rr_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a tenure-level reference model.
module tb_mux153_rr_arbiter;

  localparam int W  = 4;
  localparam int SC = 1;
  localparam int HM = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] req = '0;
  logic [1:0]   half_en = 2'b11;
  logic [W-1:0] gnt;
  logic [1:0]   A_B;
  logic         G1_n;
  logic         G2_n;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: who owns the mux, how much setup time is left,
  // and how long the current tenure has lasted.
  int m_owner;
  int m_setup_left;
  int m_held;
  int m_last;
  int m_sel;
  int m_gnt;
  int m_g1n;
  int m_g2n;

  mux153_rr_arbiter #(.WIDTH(W), .SETUP_CYC(SC), .HOLD_MAX(HM)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .half_en (half_en),
    .gnt     (gnt),
    .A_B     (A_B),
    .G1_n    (G1_n),
    .G2_n    (G2_n),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
  endtask

  task automatic model_edge();
    int c;
    if (!rst_n) begin
      m_owner = -1; m_setup_left = 0; m_held = 0;
      m_last = W - 1; m_sel = 0;
      m_gnt = 0; m_g1n = 1; m_g2n = 1;
    end else if (m_owner < 0) begin
      for (int i = 1; i <= W; i++) begin
        c = (m_last + i) % W;
        if (m_owner < 0 && req[c]) begin
          m_owner = c; m_sel = c; m_last = c; m_setup_left = SC;
        end
      end
    end else if (m_setup_left > 0) begin
      if (!req[m_owner]) begin
        m_owner = -1;
      end else begin
        m_setup_left--;
        if (m_setup_left == 0) begin
          m_held = 0;
          m_gnt = 1 << m_owner;
          m_g1n = half_en[0] ? 0 : 1;
          m_g2n = half_en[1] ? 0 : 1;
        end
      end
    end else begin
      m_held++;
      if (!req[m_owner] || (HM != 0 && m_held >= HM)) begin
        m_owner = -1; m_gnt = 0; m_g1n = 1; m_g2n = 1;
      end else begin
        m_g1n = half_en[0] ? 0 : 1;
        m_g2n = half_en[1] ? 0 : 1;
      end
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_eq("gnt",  32'(gnt),  32'(m_gnt));
      check_eq("A_B",  32'(A_B),  32'(m_sel));
      check_eq("G1_n", 32'(G1_n), 32'(m_g1n));
      check_eq("G2_n", 32'(G2_n), 32'(m_g2n));
      check_eq("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    m_owner = -1; m_setup_left = 0; m_held = 0; m_last = W - 1;
    m_sel = 0; m_gnt = 0; m_g1n = 1; m_g2n = 1;

    // Idle after reset
    do_reset();
    req = '0;
    step(10);

    // Single requester on input 2, held long enough to see hold expiry
    req = 4'b0100;
    step(40);
    req = '0;
    step(3);

    // All inputs requesting: rotating 16-cycle tenures
    req = 4'b1111;
    step(80);
    req = '0;
    step(3);

    // Request drops during setup, pending input 3 is served next
    do_reset();
    req = 4'b1010;
    step(1);
    req = 4'b1000;
    step(6);
    req = '0;
    step(3);

    // Half-enable mask changes mid-grant
    do_reset();
    half_en = 2'b01;
    req = 4'b0001;
    step(4);
    half_en = 2'b10;
    step(3);
    half_en = 2'b11;
    req = '0;
    step(3);

    // Reset in the middle of a grant to input 2
    req = 4'b0100;
    step(5);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    req = 4'b0101;
    step(6);
    req = '0;
    step(3);

    // Random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 19) == 0) half_en = 2'($urandom_range(0, 3));
      for (int b = 0; b < W; b++) begin
        if (!req[b]) begin
          if ($urandom_range(0, 7) == 0) req[b] = 1'b1;
        end else if (gnt[b]) begin
          if ($urandom_range(0, 9) == 0) req[b] = 1'b0;
        end else begin
          if ($urandom_range(0, 39) == 0) req[b] = 1'b0;
        end
      end
      step(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
